jk_cmd_seq: RTL and testbench
=============================

Name: jk_cmd_seq

Overview:
Command sequencer that sits directly upstream of the JK flip-flop stage and generates its j, k, preset and rst controls. It accepts one command at a time over a valid/ready handshake and drives the flip-flop for the required number of cycles. It then checks the flip-flop's q output against the expected value and reports completion with a done pulse and a pass/fail error flag.

Parameters:
CNT_W, 8, width of the toggle count field in a command; maximum toggles per command = 2^CNT_W-1.

Ports:
clk  in  1  single clock, rising-edge.
rst  in  1  reset; asynchronous, active-high.
cmd_valid  in  1  command present.
cmd_op  in  3  opcode, see Behaviour.
cmd_cnt  in  CNT_W  toggle count; used by TOGGLE only.
cmd_ready  out  1  sequencer can accept a command.
q_fb  in  1  q fed back from the downstream JK flip-flop.
j  out  1  JK j input drive.
k  out  1  JK k input drive.
ff_preset  out  1  flip-flop preset drive.
ff_rst  out  1  flip-flop reset drive.
done  out  1  one-cycle pulse: command finished.
err  out  1  valid with done only: q_fb mismatched the expected value, or the opcode was illegal.

Behaviour:
- Opcodes:
  - 0 NOP: no drive; expected = captured q.
  - 1 CLEAR: j=0, k=1 for 1 cycle; expected 0.
  - 2 SET: j=1, k=0 for 1 cycle; expected 1.
  - 3 TOGGLE: j=k=1 for cmd_cnt cycles; expected = captured q XOR cmd_cnt[0].
  - 4 FORCE_RST: ff_rst=1 for 1 cycle; expected 0.
  - 5 FORCE_PRE: ff_preset=1 for 1 cycle; expected 1.
  - 6 and 7: illegal.
- All outputs are registered.
- Reset values: cmd_ready=0, j=k=ff_preset=ff_rst=0, done=0, err=0, state IDLE, count=0, expected=0.
- cmd_ready rises at the first clk edge after rst deasserts.
- FSM states: IDLE, DRIVE, CHECK.
- IDLE: cmd_ready=1; all drive outputs 0. Accept occurs on an edge where cmd_valid&cmd_ready (edge E0).
  - On accept: latch op and cnt, capture q_fb, compute expected, and drop cmd_ready.
  - Next state is DRIVE with drives asserted, except NOP, TOGGLE with cnt=0 and illegal ops, which go to CHECK with no drive.
- DRIVE: drive outputs held constant while the internal down-counter (loaded with cnt, or 1) decrements each edge.
  - On the edge where the counter reaches 0, all drives return to 0 and the state moves to CHECK.
  - A TOGGLE of N therefore presents j=k=1 for exactly N clk cycles.
- CHECK: one cycle, drives 0; the flip-flop has already sampled the last drive, so q_fb is final.
  - At the next edge: done=1 for one cycle and err=(q_fb!=expected) or illegal op; state goes to IDLE and cmd_ready=1.
- Latency: done is high in the cycle after edge E0+N+1. N = drive cycles (1 for single-cycle ops, cnt for TOGGLE, 0 for no-drive ops).
- Back-to-back: a new command may be accepted on the same edge that done is presented. done and cmd_ready are both high in that cycle.
- ff_preset and ff_rst are never asserted together; j/k are always 0 while either is asserted.
- cmd_op and cmd_cnt are sampled only at accept; changes while busy are ignored. cmd_valid while cmd_ready=0 is ignored, not queued.
- The counter is CNT_W bits and never wraps: its load value is at most 2^CNT_W-1, and it stops at 0.
- rst asserted mid-command: immediate return to reset values. Drives drop asynchronously, no done/err is produced, and the command is lost.
- q_fb is unknown until the flip-flop is first cleared or set. The bench starts with CLEAR or FORCE_RST; a NOP or TOGGLE issued before that has undefined err.

Decomposition:
- Shared package jk_cmd_pkg holds:
  - the opcode constants (OP_NOP..OP_FORCE_PRE, 3-bit);
  - the FSM state encoding (ST_IDLE, ST_DRIVE, ST_CHECK);
  - a function returning the drive pattern {j,k,preset,rst} for an opcode.
- One natural sub-module: jk_drive_cnt, a loadable CNT_W down-counter with zero flag. All other logic stays flat in jk_cmd_seq.

Test Plan:
- Reset with rst=1 for 3 cycles, then release -> all outputs 0 during reset; cmd_ready=1 after the first edge post-release.
- CLEAR then SET, each accepted in IDLE -> k=1 for 1 cycle, then j=1 for 1 cycle; done two cycles after each accept; err=0; q_fb ends at 1.
- TOGGLE cnt=5 from q=0 -> j=k=1 for exactly 5 cycles; done after E0+6; expected 1; err=0. Then TOGGLE cnt=0 -> no drive; done after E0+1; err=0.
- FORCE_PRE, then FORCE_RST back-to-back (second cmd_valid held) -> ff_preset pulses 1 cycle and ff_rst pulses 1 cycle, never overlapping. The second accept lands on the first command's done edge.
- Illegal op 6 -> no drive asserted; done with err=1 after E0+1. A stuck-at-0 q_fb model with SET -> done with err=1.
- rst asserted during the 3rd cycle of TOGGLE cnt=10 -> j=k drop to 0 immediately; no done pulse. After release, a CLEAR completes normally with err=0.

Source files
------------

// File: rtl/jk_cmd_pkg.sv
// Shared definitions for the JK flip-flop command sequencer.
//   - 3-bit opcode constants (OP_NOP .. OP_FORCE_PRE; 6 and 7 are illegal)
//   - FSM state encoding (ST_IDLE, ST_DRIVE, ST_CHECK)
//   - drive_t: the {j, k, preset, rst} drive bundle presented to the flip-flop
//   - helper functions: drive pattern per opcode, illegal-opcode test and the
//     expected final q value of a command.
package jk_cmd_pkg;

  localparam logic [2:0] OP_NOP       = 3'd0;
  localparam logic [2:0] OP_CLEAR     = 3'd1;
  localparam logic [2:0] OP_SET       = 3'd2;
  localparam logic [2:0] OP_TOGGLE    = 3'd3;
  localparam logic [2:0] OP_FORCE_RST = 3'd4;
  localparam logic [2:0] OP_FORCE_PRE = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2
  } state_e;

  typedef struct packed {
    logic j;
    logic k;
    logic preset;
    logic rst;
  } drive_t;

  // Drive bundle held on the flip-flop while a command is in ST_DRIVE.
  // NOP and illegal opcodes drive nothing; preset/rst never combine with j/k.
  function automatic drive_t drive_pattern(input logic [2:0] op);
    drive_t d;
    d = '{j: 1'b0, k: 1'b0, preset: 1'b0, rst: 1'b0};
    case (op)
      OP_CLEAR:     d.k      = 1'b1;
      OP_SET:       d.j      = 1'b1;
      OP_TOGGLE:    begin
        d.j = 1'b1;
        d.k = 1'b1;
      end
      OP_FORCE_RST: d.rst    = 1'b1;
      OP_FORCE_PRE: d.preset = 1'b1;
      default:      d        = '{j: 1'b0, k: 1'b0, preset: 1'b0, rst: 1'b0};
    endcase
    return d;
  endfunction

  function automatic logic is_illegal(input logic [2:0] op);
    return (op > OP_FORCE_PRE);
  endfunction

  // Value q must hold once the command has been applied. q_cap is q at
  // accept; cnt_lsb is the toggle count parity (odd count inverts q).
  function automatic logic expected_val(input logic [2:0] op,
                                        input logic       q_cap,
                                        input logic       cnt_lsb);
    logic e;
    case (op)
      OP_NOP:       e = q_cap;
      OP_CLEAR:     e = 1'b0;
      OP_SET:       e = 1'b1;
      OP_TOGGLE:    e = q_cap ^ cnt_lsb;
      OP_FORCE_RST: e = 1'b0;
      OP_FORCE_PRE: e = 1'b1;
      default:      e = 1'b0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/jk_drive_cnt.sv
// Loadable down-counter that times how long the sequencer holds its drives.
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   load_i       load load_val_i (takes priority over dec_i)
//   load_val_i   value to load, CNT_W bits
//   dec_i        decrement by one; saturates at zero, never wraps
//   zero_o       counter is zero
//   last_o       counter is one (the next decrement reaches zero)
module jk_drive_cnt
  import jk_cmd_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load wins, otherwise decrement while non-zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);
  assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/jk_cmd_seq.sv
// Command sequencer driving a downstream JK flip-flop.
// Accepts one command at a time (cmd_valid/cmd_ready), drives j/k/preset/rst
// for the command's duration, then compares q_fb with the expected value and
// reports a one-cycle done pulse with err.
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   cmd_valid    command present
//   cmd_op       opcode (see jk_cmd_pkg)
//   cmd_cnt      toggle count, TOGGLE only
//   cmd_ready    sequencer idle and able to accept
//   q_fb         q from the downstream flip-flop
//   j, k         JK inputs
//   ff_preset    flip-flop preset drive
//   ff_rst       flip-flop reset drive
//   done         one-cycle completion pulse
//   err          with done: q mismatch or illegal opcode
module jk_cmd_seq
  import jk_cmd_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  output logic             cmd_ready,
  input  logic             q_fb,
  output logic             j,
  output logic             k,
  output logic             ff_preset,
  output logic             ff_rst,
  output logic             done,
  output logic             err
);

  state_e           state_q;
  drive_t           drive_q;
  logic             cmd_ready_q;
  logic             done_q;
  logic             err_q;
  logic             exp_q;
  logic             illegal_q;

  logic             accept_s;
  drive_t           pat_s;
  logic             no_drive_s;
  logic [CNT_W-1:0] load_val_s;
  logic             exp_d;
  logic             cnt_load_s;
  logic             cnt_dec_s;
  logic             cnt_zero_s;
  logic             cnt_last_s;
  logic             drive_end_s;

  // Decode the offered command and decide when the drive window closes.
  always_comb begin
    accept_s    = (state_q == ST_IDLE) && cmd_ready_q && cmd_valid;
    pat_s       = drive_pattern(cmd_op);
    // NOP, illegal ops and a zero-length TOGGLE skip straight to the check.
    no_drive_s  = (pat_s == drive_t'(4'b0000)) ||
                  ((cmd_op == OP_TOGGLE) && (cmd_cnt == '0));
    load_val_s  = (cmd_op == OP_TOGGLE) ? cmd_cnt : CNT_W'(1);
    exp_d       = expected_val(cmd_op, q_fb, cmd_cnt[0]);
    cnt_load_s  = accept_s && !no_drive_s;
    cnt_dec_s   = (state_q == ST_DRIVE);
    // Zero is unreachable inside DRIVE; treating it as the end keeps the FSM
    // from sticking there if the counter were ever disturbed.
    drive_end_s = cnt_last_s || cnt_zero_s;
  end

  jk_drive_cnt #(
    .CNT_W(CNT_W)
  ) u_drive_cnt (
    .clk       (clk),
    .rst       (rst),
    .load_i    (cnt_load_s),
    .load_val_i(load_val_s),
    .dec_i     (cnt_dec_s),
    .zero_o    (cnt_zero_s),
    .last_o    (cnt_last_s)
  );

  // Sequencer FSM with registered drive, handshake and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      drive_q     <= drive_t'(4'b0000);
      cmd_ready_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      exp_q       <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          drive_q <= drive_t'(4'b0000);
          if (accept_s) begin
            cmd_ready_q <= 1'b0;
            exp_q       <= exp_d;
            illegal_q   <= is_illegal(cmd_op);
            if (no_drive_s) begin
              state_q <= ST_CHECK;
            end else begin
              state_q <= ST_DRIVE;
              drive_q <= pat_s;
            end
          end else begin
            // Also raises ready on the first edge after reset release.
            cmd_ready_q <= 1'b1;
          end
        end
        ST_DRIVE: begin
          if (drive_end_s) begin
            drive_q <= drive_t'(4'b0000);
            state_q <= ST_CHECK;
          end else begin
            drive_q <= drive_q;
          end
        end
        ST_CHECK: begin
          // The flip-flop sampled the last drive one edge ago, so q_fb is final.
          done_q      <= 1'b1;
          err_q       <= (q_fb != exp_q) || illegal_q;
          cmd_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: begin
          drive_q     <= drive_t'(4'b0000);
          cmd_ready_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign j         = drive_q.j;
  assign k         = drive_q.k;
  assign ff_preset = drive_q.preset;
  assign ff_rst    = drive_q.rst;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_jk_cmd_seq.sv
// Self-checking bench for jk_cmd_seq. Contains a behavioural JK flip-flop
// (with a stuck-at-0 feedback option) and a per-command reference model
// computed from the opcode rules: drive length, drive pattern, final q,
// expected value and err.
module tb_jk_cmd_seq;

  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic [2:0]       cmd_op;
  logic [CNT_W-1:0] cmd_cnt;
  logic             cmd_ready;
  logic             q_fb;
  logic             j;
  logic             k;
  logic             ff_preset;
  logic             ff_rst;
  logic             done;
  logic             err;

  int   errors = 0;
  int   checks = 0;
  logic ff_q   = 1'b0;
  logic stuck  = 1'b0;
  logic ref_q  = 1'b0;

  jk_cmd_seq #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_op   (cmd_op),
    .cmd_cnt  (cmd_cnt),
    .cmd_ready(cmd_ready),
    .q_fb     (q_fb),
    .j        (j),
    .k        (k),
    .ff_preset(ff_preset),
    .ff_rst   (ff_rst),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream JK flip-flop with synchronous preset/reset.
  always @(posedge clk) begin
    if (ff_rst) ff_q <= 1'b0;
    else if (ff_preset) ff_q <= 1'b1;
    else begin
      case ({j, k})
        2'b01:   ff_q <= 1'b0;
        2'b10:   ff_q <= 1'b1;
        2'b11:   ff_q <= ~ff_q;
        default: ff_q <= ff_q;
      endcase
    end
  end

  assign q_fb = stuck ? 1'b0 : ff_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one command at a negedge with cmd_ready high, then check every
  // cycle until done is presented. Ends at the negedge where done is high.
  task automatic run_cmd(input logic [2:0] op, input logic [CNT_W-1:0] cnt,
                         input bit hold, input bit stuck_fb);
    int         n;
    logic [3:0] pat;
    logic       q_cap;
    logic       q_after;
    logic       exp_val;
    logic       obs_final;
    logic       err_exp;
    pat     = 4'b0000;
    n       = 0;
    q_after = ref_q;
    exp_val = 1'b0;
    q_cap   = stuck_fb ? 1'b0 : ref_q;
    case (op)
      3'd0: begin n = 0;       exp_val = q_cap;                end
      3'd1: begin n = 1;       pat = 4'b0100; q_after = 1'b0; exp_val = 1'b0; end
      3'd2: begin n = 1;       pat = 4'b1000; q_after = 1'b1; exp_val = 1'b1; end
      3'd3: begin n = int'(cnt); pat = 4'b1100;
                  q_after = ref_q ^ cnt[0]; exp_val = q_cap ^ cnt[0]; end
      3'd4: begin n = 1;       pat = 4'b0001; q_after = 1'b0; exp_val = 1'b0; end
      3'd5: begin n = 1;       pat = 4'b0010; q_after = 1'b1; exp_val = 1'b1; end
      default: begin n = 0; end
    endcase
    obs_final = stuck_fb ? 1'b0 : q_after;
    err_exp   = (op > 3'd5) || (obs_final != exp_val);

    chk("ready_at_issue", 32'(cmd_ready), 32'd1);
    stuck     = stuck_fb;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_cnt   = cnt;
    for (int c = 1; c <= n + 2; c++) begin
      @(negedge clk);
      if (c == 1) begin
        cmd_valid = hold;
        if (hold) begin
          cmd_op  = 3'($urandom_range(0, 7));
          cmd_cnt = CNT_W'($urandom);
        end
      end
      chk("drive", 32'({j, k, ff_preset, ff_rst}), (c <= n) ? 32'(pat) : 32'd0);
      chk("done", 32'(done), 32'(c == n + 2));
      chk("ready", 32'(cmd_ready), 32'(c == n + 2));
      if (c == n + 2) chk("err", 32'(err), 32'(err_exp));
    end
    ref_q = q_after;
    stuck = 1'b0;
  endtask

  initial begin
    logic [2:0]       r_op;
    logic [CNT_W-1:0] r_cnt;
    bit               r_hold;
    bit               r_stuck;
    bit               prev_hold;

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_cnt   = '0;

    // Reset: all outputs low while held, ready one edge after release.
    repeat (3) begin
      @(negedge clk);
      chk("reset_outs", 32'({cmd_ready, j, k, ff_preset, ff_rst, done, err}), 32'd0);
    end
    rst = 1'b0;
    #1;
    chk("ready_before_edge", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk("ready_after_release", 32'(cmd_ready), 32'd1);
    chk("idle_outs", 32'({j, k, ff_preset, ff_rst, done, err}), 32'd0);

    // CLEAR then SET.
    run_cmd(3'd1, 8'd0, 1'b0, 1'b0);
    run_cmd(3'd2, 8'd0, 1'b0, 1'b0);
    chk("q_after_set", 32'(q_fb), 32'd1);

    // TOGGLE 5 from q=0, then TOGGLE 0.
    run_cmd(3'd1, 8'd0, 1'b0, 1'b0);
    run_cmd(3'd3, 8'd5, 1'b0, 1'b0);
    chk("q_after_toggle5", 32'(q_fb), 32'd1);
    run_cmd(3'd3, 8'd0, 1'b0, 1'b0);

    // FORCE_PRE then FORCE_RST back-to-back with cmd_valid held.
    run_cmd(3'd5, 8'd0, 1'b1, 1'b0);
    run_cmd(3'd4, 8'd0, 1'b0, 1'b0);
    chk("q_after_force_rst", 32'(q_fb), 32'd0);

    // Illegal opcodes and a stuck-at-0 feedback.
    run_cmd(3'd6, 8'd3, 1'b0, 1'b0);
    run_cmd(3'd7, 8'd0, 1'b0, 1'b0);
    run_cmd(3'd2, 8'd0, 1'b0, 1'b1);

    // Reset during the third drive cycle of TOGGLE 10.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 3'd3;
    cmd_cnt   = 8'd10;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("mid_toggle_c1", 32'({j, k}), 32'd3);
    @(negedge clk);
    chk("mid_toggle_c2", 32'({j, k}), 32'd3);
    @(negedge clk);
    chk("mid_toggle_c3", 32'({j, k}), 32'd3);
    rst = 1'b1;
    #1;
    chk("async_drop", 32'({cmd_ready, j, k, ff_preset, ff_rst, done, err}), 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("no_done_in_rst", 32'({done, j, k}), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rerelease", 32'(cmd_ready), 32'd1);
    chk("no_done_after_abort", 32'(done), 32'd0);
    // Two toggles were sampled before reset, so q is unchanged.
    run_cmd(3'd1, 8'd0, 1'b0, 1'b0);

    // Randomized command stream.
    prev_hold = 1'b0;
    for (int i = 0; i < 40; i++) begin
      r_op    = 3'($urandom_range(0, 7));
      r_cnt   = CNT_W'($urandom_range(0, 12));
      r_hold  = (i < 39) && ($urandom_range(0, 2) == 0);
      r_stuck = ($urandom_range(0, 5) == 0);
      if (!prev_hold && ($urandom_range(0, 2) == 0)) begin
        @(negedge clk);
        chk("idle_gap", 32'({cmd_ready, j, k, ff_preset, ff_rst, done}), 32'h20);
      end
      run_cmd(r_op, r_cnt, r_hold, r_stuck);
      prev_hold = r_hold;
    end

    // Longest toggle count.
    run_cmd(3'd3, 8'd255, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
